// File: rtl/uart_pwm_pkg.sv
// Shared constants and state encodings for the UART-driven PWM controller.
// Imported by the interface, the byte receiver and the top level.
package uart_pwm_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ADDR_TOP  = 8'h80;
    localparam int         ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        DHI,
        DLO,
        CHK
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                  input logic [7:0] h,
                                                  input logic [7:0] l);
        return a ^ h ^ l;
    endfunction

endpackage

// File: rtl/uart_pwm_ctrl_if.sv
// Board-facing signal bundle of uart_pwm_ctrl: UART line in, PWM and status out.
// The slave modport is the controller, the master modport is whatever drives the line.
interface uart_pwm_ctrl_if
    import uart_pwm_pkg::*;
#(
    parameter int NUM_CH = 9
);

    logic                 uart_rx;
    logic [NUM_CH-1:0]    pwm_out;
    logic                 frame_ok;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic [7:0]           last_addr;
    logic [15:0]          last_data;

    modport slave (
        input  uart_rx,
        output pwm_out,
        output frame_ok,
        output frame_err,
        output err_count,
        output last_addr,
        output last_data
    );

    modport master (
        output uart_rx,
        input  pwm_out,
        input  frame_ok,
        input  frame_err,
        input  err_count,
        input  last_addr,
        input  last_data
    );

endinterface

// File: rtl/uart_pwm_ctrl_byte_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, half-bit start recheck, centre sampling.
// Emits a 1-clk byte_valid for good bytes and a 1-clk stop_err when the stop bit is low.
module uart_byte_rx
    import uart_pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic             byte_valid_d, stop_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_d;
            clk_cnt    <= clk_cnt_d;
            bit_idx    <= bit_idx_d;
            shift      <= shift_d;
            byte_valid <= byte_valid_d;
            stop_err   <= stop_err_d;
        end
    end

    always_comb begin
        state_d      = state;
        clk_cnt_d    = clk_cnt;
        bit_idx_d    = bit_idx;
        shift_d      = shift;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = RX_START;
            end
            RX_START: begin
                // A glitch shorter than half a bit falls back to idle here.
                if (clk_cnt == HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                    else                 bit_idx_d = bit_idx + 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL) begin
                    clk_cnt_d    = '0;
                    state_d      = RX_IDLE;
                    byte_valid_d = rx_sync;
                    stop_err_d   = !rx_sync;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_pwm_ctrl.sv
// Framed UART PWM controller: SYNC/ADDR/DATA_HI/DATA_LO/CHK packets load shadow
// registers that are copied into the active PWM bank at each period boundary.
module uart_pwm_ctrl
    import uart_pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_CH       = 9,
    parameter int RES          = 16,
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_pwm_ctrl_if.slave  bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);

    logic       byte_valid, stop_err;
    logic [7:0] byte_data;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (bus.uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    frame_state_t         state, state_d;
    logic [7:0]           addr_q, dhi_q, dlo_q;
    logic [TMR_W-1:0]     timer;
    logic                 timeout_hit, addr_ok, accept, reject;
    logic                 frame_ok_q, frame_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [7:0]           last_addr_q;
    logic [15:0]          last_data_q, data_word;

    logic [RES-1:0]       shadow_duty [NUM_CH];
    logic [RES-1:0]       shadow_duty_d [NUM_CH];
    logic [RES-1:0]       active_duty [NUM_CH];
    logic [RES-1:0]       shadow_top, shadow_top_d, active_top, cnt;
    logic [NUM_CH-1:0]    pwm_q;

    assign data_word   = {dhi_q, dlo_q};
    assign addr_ok     = ({24'd0, addr_q} < 32'(NUM_CH)) || (addr_q == ADDR_TOP);
    // A byte landing on the expiry cycle counts as activity, not a timeout.
    assign timeout_hit = (state != HUNT) && !byte_valid &&
                         (timer == TMR_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        reject  = 1'b0;
        if (byte_valid) begin
            unique case (state)
                HUNT:    if (byte_data == SYNC_BYTE) state_d = ADDR;
                ADDR:    state_d = DHI;
                DHI:     state_d = DLO;
                DLO:     state_d = CHK;
                CHK: begin
                    state_d = HUNT;
                    if (byte_data == frame_checksum(addr_q, dhi_q, dlo_q) && addr_ok)
                        accept = 1'b1;
                    else
                        reject = 1'b1;
                end
                default: state_d = HUNT;
            endcase
        end else if ((stop_err && state != HUNT) || timeout_hit) begin
            state_d = HUNT;
            reject  = 1'b1;
        end
    end

    always_comb begin
        shadow_duty_d = shadow_duty;
        shadow_top_d  = shadow_top;
        if (accept) begin
            if (addr_q == ADDR_TOP) shadow_top_d = data_word[RES-1:0];
            for (int i = 0; i < NUM_CH; i++)
                if (addr_q == 8'(i)) shadow_duty_d[i] = data_word[RES-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            timer       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            if (byte_valid && state == ADDR) addr_q <= byte_data;
            if (byte_valid && state == DHI)  dhi_q  <= byte_data;
            if (byte_valid && state == DLO)  dlo_q  <= byte_data;
            if (state == HUNT || byte_valid) timer <= '0;
            else                             timer <= timer + 1'b1;
            frame_ok_q  <= accept;
            frame_err_q <= reject;
            if (reject && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (accept) begin
                last_addr_q <= addr_q;
                last_data_q <= data_word;
            end
        end
    end

    // Shadows feed the active bank through their next-state value so a write
    // coinciding with the wrap is not lost for a whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty[i] <= '0;
                active_duty[i] <= '0;
            end
            shadow_top <= '1;
            active_top <= '1;
            cnt        <= '0;
            pwm_q      <= '0;
        end else begin
            shadow_duty <= shadow_duty_d;
            shadow_top  <= shadow_top_d;
            if (cnt == active_top) begin
                cnt         <= '0;
                active_duty <= shadow_duty_d;
                active_top  <= shadow_top_d;
            end else begin
                cnt <= cnt + 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++)
                pwm_q[i] <= (cnt < active_duty[i]);
        end
    end

    assign bus.pwm_out   = pwm_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_cnt_q;
    assign bus.last_addr = last_addr_q;
    assign bus.last_data = last_data_q;

endmodule

// File: tb/tb_uart_pwm_ctrl.sv
// Directed bench for uart_pwm_ctrl: frames are serialised onto uart_rx and the
// status outputs and PWM waveforms are compared against hand-computed values.
module tb_uart_pwm_ctrl;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   ok_pulses   = 0;
    int   err_pulses  = 0;

    uart_pwm_ctrl_if #(.NUM_CH(9)) bus ();

    uart_pwm_ctrl #(
        .CLKS_PER_BIT (CPB),
        .NUM_CH       (9),
        .RES          (16),
        .TIMEOUT_CLKS (200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_ok === 1'b1)  ok_pulses++;
        if (bus.frame_err === 1'b1) err_pulses++;
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uart_rx = 1'b1;
        repeat (CPB + 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(h);
        send_byte(l);
        send_byte(c);
        repeat (4) @(negedge clk);
    endtask

    // Counts high samples of one channel over n consecutive clocks.
    task automatic count_high(input int ch, input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.pwm_out[ch] === 1'b1) highs++;
            @(negedge clk);
        end
    endtask

    initial begin
        int ok0, err0, waited, highs, rises, second_rise, others, prev;

        rst_n       = 1'b0;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_pwm",       32'(bus.pwm_out),   32'h0);
        check_output("rst_frame_ok",  32'(bus.frame_ok),  32'h0);
        check_output("rst_frame_err", 32'(bus.frame_err), 32'h0);
        check_output("rst_err_count", 32'(bus.err_count), 32'h0);
        check_output("rst_last_addr", 32'(bus.last_addr), 32'h0);
        check_output("rst_last_data", 32'(bus.last_data), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] step 1: program TOP=9");
        ok0 = ok_pulses; err0 = err_pulses;
        send_frame(8'h80, 8'h00, 8'h09, 8'h89);
        check_output("t1_ok_pulses",  32'(ok_pulses - ok0),   32'd1);
        check_output("t1_err_pulses", 32'(err_pulses - err0), 32'd0);
        check_output("t1_last_addr",  32'(bus.last_addr),     32'h80);
        check_output("t1_last_data",  32'(bus.last_data),     32'h0009);

        $display("[TB] step 2: channel 3 duty 4");
        ok0 = ok_pulses;
        send_frame(8'h03, 8'h00, 8'h04, 8'h07);
        check_output("t2_ok_pulses", 32'(ok_pulses - ok0), 32'd1);
        check_output("t2_pwm_before_wrap", 32'(bus.pwm_out), 32'h0);

        // Both shadows land on the first wrap of the reset period (65536 clks).
        waited = 0;
        while (bus.pwm_out[3] !== 1'b1 && waited < 70000) begin
            @(negedge clk);
            waited++;
        end
        check_output("t2_wrap_seen", 32'(waited < 70000), 32'd1);
        highs = 0; rises = 0; second_rise = 0; others = 0; prev = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.pwm_out[3] === 1'b1) highs++;
            if (bus.pwm_out[3] === 1'b1 && prev == 0) begin
                rises++;
                if (rises == 2) second_rise = i;
            end
            prev = (bus.pwm_out[3] === 1'b1) ? 1 : 0;
            if ((bus.pwm_out & 9'h1F7) !== 9'h0) others++;
            @(negedge clk);
        end
        check_output("t2_ch3_highs",      32'(highs),       32'd40);
        check_output("t2_ch3_rises",      32'(rises),       32'd10);
        check_output("t1_period",         32'(second_rise), 32'd10);
        check_output("t2_other_channels", 32'(others),      32'd0);

        $display("[TB] step 3: rejected frames");
        ok0 = ok_pulses; err0 = err_pulses;
        send_frame(8'h02, 8'h12, 8'h34, 8'h00);
        check_output("t3_bad_chk_err",   32'(err_pulses - err0), 32'd1);
        check_output("t3_err_count_1",   32'(bus.err_count),     32'd1);
        repeat (25) @(negedge clk);
        others = 0;
        for (int i = 0; i < 30; i++) begin
            if ((bus.pwm_out & 9'h1F7) !== 9'h0) others++;
            @(negedge clk);
        end
        check_output("t3_ch2_unchanged", 32'(others), 32'd0);
        send_frame(8'h09, 8'h00, 8'h01, 8'h08);
        check_output("t3_range_err",     32'(err_pulses - err0), 32'd2);
        check_output("t3_err_count_2",   32'(bus.err_count),     32'd2);
        check_output("t3_no_ok",         32'(ok_pulses - ok0),   32'd0);
        check_output("t3_last_addr",     32'(bus.last_addr),     32'h03);
        check_output("t3_last_data",     32'(bus.last_data),     32'h0004);

        $display("[TB] step 4: inter-byte timeout");
        ok0 = ok_pulses; err0 = err_pulses;
        send_byte(8'hA5);
        send_byte(8'h05);
        repeat (250) @(negedge clk);
        check_output("t4_timeout_err", 32'(err_pulses - err0), 32'd1);
        check_output("t4_err_count_3", 32'(bus.err_count),     32'd3);
        send_frame(8'h05, 8'h00, 8'h0A, 8'h0F);
        check_output("t4_ok_pulses",   32'(ok_pulses - ok0),   32'd1);
        check_output("t4_last_addr",   32'(bus.last_addr),     32'h05);
        check_output("t4_last_data",   32'(bus.last_data),     32'h000A);
        repeat (25) @(negedge clk);
        count_high(5, 20, highs);
        check_output("t4_ch5_const_high", 32'(highs), 32'd20);

        $display("[TB] step 5: garbage before sync");
        ok0 = ok_pulses; err0 = err_pulses;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_frame(8'h01, 8'h00, 8'h03, 8'h02);
        check_output("t5_no_err",     32'(err_pulses - err0), 32'd0);
        check_output("t5_ok_pulses",  32'(ok_pulses - ok0),   32'd1);
        check_output("t5_last_addr",  32'(bus.last_addr),     32'h01);
        check_output("t5_err_count",  32'(bus.err_count),     32'd3);
        repeat (25) @(negedge clk);
        count_high(1, 10, highs);
        check_output("t5_ch1_highs", 32'(highs), 32'd3);

        $display("[TB] step 6: reset mid-frame");
        ok0 = ok_pulses; err0 = err_pulses;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        #2 rst_n = 1'b0;
        #1;
        check_output("t6_rst_pwm",       32'(bus.pwm_out),   32'h0);
        check_output("t6_rst_err_count", 32'(bus.err_count), 32'h0);
        check_output("t6_rst_last_addr", 32'(bus.last_addr), 32'h0);
        check_output("t6_rst_last_data", 32'(bus.last_data), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t6_no_pulses", 32'((ok_pulses - ok0) + (err_pulses - err0)), 32'd0);
        send_frame(8'h07, 8'h00, 8'h02, 8'h05);
        check_output("t6_ok_pulses", 32'(ok_pulses - ok0), 32'd1);
        check_output("t6_err_count", 32'(bus.err_count),   32'd0);
        check_output("t6_last_addr", 32'(bus.last_addr),   32'h07);
        check_output("t6_last_data", 32'(bus.last_data),   32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
